cache_arbiter: RTL

- Arbitrates line-fill and write-back traffic from the I-cache (IF stage) and D-cache (MEM stage) onto the single shared physical-memory / L2 port of the pipelined LC-3b.
- Holds one outstanding transaction at a time. Latches the winner's address, operation and write data, drives the memory port until pmem_resp, then returns the line to that requester with a one-cycle resp pulse.

---
 rtl/cache_arbiter.sv | 132 +++++++++++++
 1 files changed

// File: rtl/cache_arbiter.sv
// Single-outstanding arbiter between the I-cache and D-cache for the shared pmem/L2 port.
// Optional ARBITER_ROUND_ROBIN_EN replaces fixed D-priority with alternating priority.
module cache_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int LINE_WIDTH = 128
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  i_pmem_read,
    input  logic [ADDR_WIDTH-1:0] i_pmem_address,
    output logic [LINE_WIDTH-1:0] i_pmem_rdata,
    output logic                  i_pmem_resp,

    input  logic                  d_pmem_read,
    input  logic                  d_pmem_write,
    input  logic [ADDR_WIDTH-1:0] d_pmem_address,
    input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
    output logic [LINE_WIDTH-1:0] d_pmem_rdata,
    output logic                  d_pmem_resp,

    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [ADDR_WIDTH-1:0] pmem_address,
    output logic [LINE_WIDTH-1:0] pmem_wdata,
    input  logic [LINE_WIDTH-1:0] pmem_rdata,
    input  logic                  pmem_resp
);

    localparam int OFFSET_BITS = $clog2(LINE_WIDTH / 8);
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~ADDR_WIDTH'((1 << OFFSET_BITS) - 1);

    typedef enum logic [2:0] {
        IDLE,
        SERVE_I,
        SERVE_D,
        RESP_I,
        RESP_D
    } state_t;

    state_t state;
    state_t state_next;
    logic   grant_i;
    logic   grant_d;
    logic   d_req;
    logic   d_wins;

    assign d_req = d_pmem_read | d_pmem_write;

`ifdef ARBITER_ROUND_ROBIN_EN
    logic last_grant;  // 0 = I granted last, 1 = D granted last

    assign d_wins = ~last_grant;

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= 1'b0;
        end else if (grant_d) begin
            last_grant <= 1'b1;
        end else if (grant_i) begin
            last_grant <= 1'b0;
        end
    end
`else
    assign d_wins = 1'b1;
`endif

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_next = state;
        grant_i    = 1'b0;
        grant_d    = 1'b0;
        case (state)
            IDLE: begin
                if (d_req && (!i_pmem_read || d_wins)) begin
                    grant_d    = 1'b1;
                    state_next = SERVE_D;
                end else if (i_pmem_read) begin
                    grant_i    = 1'b1;
                    state_next = SERVE_I;
                end
            end
            SERVE_I: if (pmem_resp) state_next = RESP_I;
            SERVE_D: if (pmem_resp) state_next = RESP_D;
            RESP_I, RESP_D: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Registered outputs: strobes/address/data are loaded on grant, strobes drop on pmem_resp.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register here samples pre-edge values.
        if (reset) begin
            pmem_read    <= 1'b0;
            pmem_write   <= 1'b0;
            pmem_address <= '0;
            pmem_wdata   <= '0;
            i_pmem_rdata <= '0;
            d_pmem_rdata <= '0;
            i_pmem_resp  <= 1'b0;
            d_pmem_resp  <= 1'b0;
        end else begin
            i_pmem_resp <= (state_next == RESP_I);
            d_pmem_resp <= (state_next == RESP_D);

            if (grant_d) begin
                pmem_address <= d_pmem_address & LINE_MASK;
                pmem_wdata   <= d_pmem_wdata;
                pmem_write   <= d_pmem_write;
                pmem_read    <= ~d_pmem_write;
            end else if (grant_i) begin
                pmem_address <= i_pmem_address & LINE_MASK;
                pmem_write   <= 1'b0;
                pmem_read    <= 1'b1;
            end else if ((state == SERVE_I || state == SERVE_D) && pmem_resp) begin
                pmem_read  <= 1'b0;
                pmem_write <= 1'b0;
                if (pmem_read && state == SERVE_I) i_pmem_rdata <= pmem_rdata;
                if (pmem_read && state == SERVE_D) d_pmem_rdata <= pmem_rdata;
            end
        end
    end

endmodule
